aes_inv_key_schedule: RTL

//  Sequential AES-128 decryption key source: accepts a cipher key, expands forward to round key 10,

---
 rtl/aes_pkg.sv | 80 ++++++++
 rtl/aes_inv_key_round.sv | 36 +++
 rtl/aes_key_schedule.sv | 33 +++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_inv_key_schedule.sv | 102 ++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: key-schedule state encoding, S-box table,
// round-constant function and word pack/unpack helpers for the row-major
// key packing (byte kN at bits [127-8N -: 8], word j = {kj, kj+4, kj+8, kj+12}).
package aes_pkg;

   localparam logic [3:0] LAST_ROUND = 4'd10;

   typedef logic [127:0] aes_key_t;
   typedef logic [31:0]  aes_word_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXPAND,
      ST_EMIT
   } ks_state_e;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Round constant for rounds 1..10; anything else yields 00.
   function automatic logic [7:0] rcon(input logic [3:0] round);
      case (round)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // Extract key word j (a state column) from the row-major packing.
   function automatic aes_word_t get_word(input aes_key_t key, input int unsigned j);
      aes_word_t w;
      for (int i = 0; i < 4; i++) begin
         w[31-8*i -: 8] = key[127-8*(j+4*i) -: 8];
      end
      return w;
   endfunction

   // Rebuild the row-major packing from four key words.
   function automatic aes_key_t pack_words(input aes_word_t w0, input aes_word_t w1,
                                           input aes_word_t w2, input aes_word_t w3);
      aes_word_t w [4];
      aes_key_t  k;
      w = '{w0, w1, w2, w3};
      for (int j = 0; j < 4; j++) begin
         for (int i = 0; i < 4; i++) begin
            k[127-8*(j+4*i) -: 8] = w[j][31-8*i -: 8];
         end
      end
      return k;
   endfunction

   function automatic aes_word_t rot_word(input aes_word_t w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_inv_key_round.sv
// Inverse single-round AES-128 key schedule step: round key r -> round key r-1.
// The S-box input is RotWord of the recovered w3, which is only known after
// undoing the xor chain, so the chain is unwound first.
module aes_inv_key_round
   import aes_pkg::*;
(
   input  logic [3:0]   round_in,
   input  logic [127:0] key_in,
   output logic [127:0] key_out
);

   aes_word_t w_w0, w_w1, w_w2, w_w3;
   aes_word_t w_rot, w_sub;
   aes_word_t w_p0, w_p1, w_p2, w_p3;

   assign w_w0  = get_word(key_in, 0);
   assign w_w1  = get_word(key_in, 1);
   assign w_w2  = get_word(key_in, 2);
   assign w_w3  = get_word(key_in, 3);

   assign w_p3  = w_w3 ^ w_w2;
   assign w_p2  = w_w2 ^ w_w1;
   assign w_p1  = w_w1 ^ w_w0;
   assign w_rot = rot_word(w_p3);

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .byte_in  (w_rot[31-8*b -: 8]),
         .byte_out (w_sub[31-8*b -: 8])
      );
   end

   assign w_p0    = w_w0 ^ w_sub ^ {rcon(round_in), 24'h0};
   assign key_out = pack_words(w_p0, w_p1, w_p2, w_p3);

endmodule

// File: rtl/aes_key_schedule.sv
// Forward single-round AES-128 key schedule step: round key r-1 -> round key r.
module aes_key_schedule
   import aes_pkg::*;
(
   input  logic [3:0]   round_in,
   input  logic [127:0] key_in,
   output logic [127:0] key_out
);

   aes_word_t w_w0, w_w1, w_w2, w_w3;
   aes_word_t w_rot, w_sub;
   aes_word_t w_n0, w_n1, w_n2, w_n3;

   assign w_w0  = get_word(key_in, 0);
   assign w_w1  = get_word(key_in, 1);
   assign w_w2  = get_word(key_in, 2);
   assign w_w3  = get_word(key_in, 3);
   assign w_rot = rot_word(w_w3);

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .byte_in  (w_rot[31-8*b -: 8]),
         .byte_out (w_sub[31-8*b -: 8])
      );
   end

   assign w_n0    = w_w0 ^ w_sub ^ {rcon(round_in), 24'h0};
   assign w_n1    = w_w1 ^ w_n0;
   assign w_n2    = w_w2 ^ w_n1;
   assign w_n3    = w_w3 ^ w_n2;
   assign key_out = pack_words(w_n0, w_n1, w_n2, w_n3);

endmodule

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] byte_in,
   output logic [7:0] byte_out
);

   assign byte_out = SBOX[byte_in];

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 decryption key source. Takes a cipher key, runs the forward schedule
// for ten cycles to reach round key 10, then streams round keys 10..0 over a
// valid/ready interface, stepping the schedule backwards once per handshake.
module aes_inv_key_schedule
   import aes_pkg::*;
(
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         key_valid_in,
   input  logic [127:0] key_in,
   output logic         key_ready_out,
   output logic         rk_valid_out,
   input  logic         rk_ready_in,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_round_out,
   output logic         rk_last_out,
   output logic         busy_out
);

   ks_state_e  r_state, w_state_nxt;
   aes_key_t   r_key, w_key_nxt;
   aes_key_t   w_key_fwd, w_key_inv;
   logic [3:0] r_rnd, w_rnd_nxt;

   aes_key_schedule u_fwd (
      .round_in (r_rnd),
      .key_in   (r_key),
      .key_out  (w_key_fwd)
   );

   aes_inv_key_round u_inv (
      .round_in (r_rnd),
      .key_in   (r_key),
      .key_out  (w_key_inv)
   );

   // State, key and round registers with synchronous reset.
   always_ff @(posedge clk_in) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst_in) begin
         r_state <= ST_IDLE;
         r_key   <= '0;
         r_rnd   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_key   <= w_key_nxt;
         r_rnd   <= w_rnd_nxt;
      end
   end

   // Next-state logic and next-key mux (load / forward / inverse / hold).
   always_comb begin
      // NOTE: defaults first so no branch leaves a signal unassigned and infers a latch.
      w_state_nxt = r_state;
      w_key_nxt   = r_key;
      w_rnd_nxt   = r_rnd;
      case (r_state)
         ST_IDLE: begin
            if (key_valid_in) begin
               w_key_nxt   = key_in;
               w_rnd_nxt   = 4'd1;
               w_state_nxt = ST_EXPAND;
            end
         end
         ST_EXPAND: begin
            w_key_nxt = w_key_fwd;
            if (r_rnd == LAST_ROUND) begin
               w_state_nxt = ST_EMIT;
            end else begin
               w_rnd_nxt = r_rnd + 4'd1;
            end
         end
         ST_EMIT: begin
            if (rk_ready_in) begin
               if (r_rnd == 4'd0) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_key_nxt = w_key_inv;
                  w_rnd_nxt = r_rnd - 4'd1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decoded from registered state only; round-key fields read zero outside EMIT.
   always_comb begin
      key_ready_out = (r_state == ST_IDLE);
      busy_out      = (r_state == ST_EXPAND) || (r_state == ST_EMIT);
      rk_valid_out  = (r_state == ST_EMIT);
      rk_out        = '0;
      rk_round_out  = '0;
      rk_last_out   = 1'b0;
      if (r_state == ST_EMIT) begin
         rk_out       = r_key;
         rk_round_out = r_rnd;
         rk_last_out  = (r_rnd == 4'd0);
      end
   end

endmodule
